bcd_display_scanner: RTL
========================

Name: bcd_display_scanner

Overview:
- Time-multiplexes NUM_DIGITS packed BCD digits onto one shared seven-segment decoder.
- Sits directly upstream of bcd_7segment: drives its 4-bit BCD input and selects the matching common-anode digit.
- A programmable prescaler paces the scan.
- Each full frame of digits is snapshotted atomically, so a display never tears mid-frame.

Parameters:
- NUM_DIGITS, 4, number of digits scanned (2..8).
- SCAN_DIV, 1000, enabled clock cycles per digit slot (>=1).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- en  in  1  scan enable; 0 freezes prescaler and all outputs.
- digits_in  in  4*NUM_DIGITS  packed BCD; digit k at [4k+3:4k], digit 0 = least significant (rightmost).
- dp_in  in  NUM_DIGITS  decimal-point request per digit.
- bcd_out  out  4  BCD for bcd_7segment.
- dp_out  out  1  decimal point for the current digit.
- anode_n  out  NUM_DIGITS  active-low digit select, one-hot-low or all ones.
- digit_idx  out  clog2(NUM_DIGITS)  index of the current slot.
- bad_digit  out  1  current snapshot digit is >9.

Behaviour:
- Reset (async assert, sync release):
  - prescaler=0, digit_idx=0, anode_n=all ones, bcd_out=0, dp_out=0, bad_digit=0.
  - Internal "running" flag=0; snapshot registers=0.
- All outputs are registered and update only on a tick.
- Tick condition: en=1 and prescaler==SCAN_DIV-1. On a tick the prescaler goes to 0; otherwise it increments while en=1.
- SCAN_DIV=1 means every enabled cycle is a tick.
- en=0 freezes the prescaler and all outputs; there is no reset of the count.
- First tick after reset:
  - running<=1, digit_idx<=0.
  - Snapshot digits_in/dp_in.
  - Drive slot 0 from the new snapshot on the same edge.
  - Latency from reset release with en=1 is SCAN_DIV edges.
- Later ticks:
  - digit_idx advances by 1.
  - NUM_DIGITS-1 wraps to 0; the snapshot is recaptured on that wrap tick, and slot 0 uses the fresh values.
- Input changes mid-frame are not visible until the next wrap.
- Slot drive on each tick, for slot k:
  - anode_n = all ones except bit k = 0.
  - bcd_out = snap digit k.
  - dp_out = snap dp k.
- Invalid digit (>9) in slot k: bcd_out=4'b1111, bad_digit=1, anode still asserted. bad_digit is otherwise 0.
- Exactly one anode bit is low at any time while running. anode_n never shows more than one 0.
- Reset mid-frame: immediate return to the reset state; the scan restarts at slot 0 with a new snapshot on the first tick.
- Prescaler width = clog2(SCAN_DIV), minimum 1 bit. The counter never exceeds SCAN_DIV-1.

Optional Feature:
- Macro LEADING_ZERO_BLANK_EN.
- Defined:
  - On each snapshot, compute a blank mask: digits from NUM_DIGITS-1 downward that are 0 with dp=0, stopping at the first nonzero digit or dp.
  - Digit 0 is never blanked.
  - Blanked slots keep their time slot (same timing), but anode_n = all ones, bcd_out=0, dp_out=0.
  - Extra port blank_out (out, 1) = 1 during a blanked slot, 0 otherwise and at reset.
- Not defined: no mask logic, no blank_out port; every slot drives its anode.

Test Plan:
- Reset behaviour:
  - Stimulus: NUM_DIGITS=4, SCAN_DIV=4, digits_in=16'h1234, en=1; release rst_n.
  - Response: anode_n=4'b1111 for 3 edges. On the 4th edge: digit_idx=0, bcd_out=4, anode_n=4'b1110.
  - Then every 4 edges: 3/1101, 2/1011, 1/0111, then back to 4/1110.
- Snapshot atomicity:
  - Stimulus: change digits_in to 16'h5678 while slot 1 is active.
  - Response: slots 2,3 still show 2,1. The wrap tick shows 8 on slot 0, then 7,6,5.
- Enable freeze:
  - Stimulus: deassert en for 10 cycles mid-slot 2.
  - Response: outputs and prescaler hold; the slot ends exactly (4 − elapsed) enabled cycles after en returns.
- Invalid digit and decimal point:
  - Stimulus: digits_in=16'h00A0, dp_in=4'b0100.
  - Response: slot 1 bcd_out=1111, bad_digit=1; slot 2 dp_out=1; all other slots bad_digit=0, dp_out=0.
- Async reset mid-frame:
  - Stimulus: pulse rst_n low for 1ns during slot 3, between clock edges.
  - Response: anode_n=1111 and digit_idx=0 immediately; the restart follows the first scenario.
- LEADING_ZERO_BLANK_EN defined:
  - Stimulus: digits_in=16'h0040.
  - Response: slots 3 and 2 have anode_n=1111 and blank_out=1; slot 1 shows 4; slot 0 shows 0 (not blanked).
  - Variant: digits_in=16'h0000 → only slot 0 is lit.

Source files
------------

// File: rtl/bcd_display_scanner.sv
// Scans NUM_DIGITS packed BCD digits onto one shared 7-segment decoder; optional LEADING_ZERO_BLANK_EN adds leading-zero blanking and a blank_out port.
// Latency: outputs are registered and change only on a prescaler tick; first slot appears SCAN_DIV enabled edges after reset release.
// Backpressure: none; en=0 freezes the prescaler and every output, and the count resumes where it stopped.
`timescale 1ns/1ps

module bcd_display_scanner #(
    parameter int NUM_DIGITS = 4,
    parameter int SCAN_DIV   = 1000
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          en,
    input  logic [4*NUM_DIGITS-1:0]       digits_in,
    input  logic [NUM_DIGITS-1:0]         dp_in,
    output logic [3:0]                    bcd_out,
    output logic                          dp_out,
    output logic [NUM_DIGITS-1:0]         anode_n,
    output logic [$clog2(NUM_DIGITS)-1:0] digit_idx,
`ifdef LEADING_ZERO_BLANK_EN
    output logic                          blank_out,
`endif
    output logic                          bad_digit
);

    localparam int IW = $clog2(NUM_DIGITS);
    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(SCAN_DIV - 1);
    localparam logic [IW-1:0] LAST_IDX  = IW'(NUM_DIGITS - 1);

    // Prescaler and scan state
    logic [PW-1:0]           prescaler;
    logic                    tick;
    logic                    running;

    // Frame snapshot, held stable for a whole scan so the display never tears
    logic [4*NUM_DIGITS-1:0] snap_digits;
    logic [NUM_DIGITS-1:0]   snap_dp;

    // Next-slot selection
    logic                    wrap;
    logic [IW-1:0]           next_idx;
    logic [4*NUM_DIGITS-1:0] src_digits;
    logic [NUM_DIGITS-1:0]   src_dp;
    logic [3:0]              sel_digit;
    logic                    sel_dp;
    logic                    sel_blank;

    // Next registered output values
    logic [3:0]              nxt_bcd;
    logic                    nxt_dp;
    logic                    nxt_bad;
    logic [NUM_DIGITS-1:0]   nxt_anode_n;

`ifdef LEADING_ZERO_BLANK_EN
    logic [NUM_DIGITS-1:0]   snap_blank;
    logic [NUM_DIGITS-1:0]   src_blank;
    logic [NUM_DIGITS-1:0]   fresh_blank;

    // Walk down from the most significant digit, blanking zeros without a
    // decimal point until the first significant digit; digit 0 always stays lit.
    function automatic logic [NUM_DIGITS-1:0] blank_mask(
        input logic [4*NUM_DIGITS-1:0] digits,
        input logic [NUM_DIGITS-1:0]   dps
    );
        logic [NUM_DIGITS-1:0] mask;
        logic                  blanking;
        mask     = '0;
        blanking = 1'b1;
        for (int j = NUM_DIGITS - 1; j >= 1; j--) begin
            if (blanking && (digits[4*j +: 4] == 4'd0) && !dps[j]) begin
                mask[j] = 1'b1;
            end else begin
                blanking = 1'b0;
            end
        end
        return mask;
    endfunction

    assign fresh_blank = blank_mask(digits_in, dp_in);
`endif

    assign tick = en && (prescaler == PRESC_MAX);

    // Prescaler: counts enabled cycles, wraps to zero on the tick, holds while en=0
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prescaler <= '0;
        end else if (en) begin
            if (prescaler == PRESC_MAX) begin
                prescaler <= '0;
            end else begin
                prescaler <= prescaler + 1'b1;
            end
        end
    end

    // Pick the slot driven on the next tick; a wrap (or the very first tick)
    // takes its data straight from the inputs, which is also what gets snapshotted
    always_comb begin
        wrap        = !running || (digit_idx == LAST_IDX);
        next_idx    = wrap ? '0 : digit_idx + 1'b1;
        src_digits  = wrap ? digits_in : snap_digits;
        src_dp      = wrap ? dp_in : snap_dp;
        sel_digit   = src_digits[{next_idx, 2'b00} +: 4];
        sel_dp      = src_dp[next_idx];
`ifdef LEADING_ZERO_BLANK_EN
        src_blank   = wrap ? fresh_blank : snap_blank;
        sel_blank   = src_blank[next_idx];
`else
        sel_blank   = 1'b0;
`endif
        nxt_anode_n = ~(NUM_DIGITS'(1) << next_idx);
        nxt_bcd     = sel_digit;
        nxt_dp      = sel_dp;
        nxt_bad     = 1'b0;
        if (sel_blank) begin
            // Blanked slot keeps its time slot but lights nothing
            nxt_anode_n = '1;
            nxt_bcd     = 4'd0;
            nxt_dp      = 1'b0;
        end else if (sel_digit > 4'd9) begin
            // Non-BCD code: force all-ones so the decoder shows its error glyph
            nxt_bcd     = 4'b1111;
            nxt_bad     = 1'b1;
        end
    end

    // Snapshot capture on the first tick after reset and on every wrap tick
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            snap_digits <= '0;
            snap_dp     <= '0;
`ifdef LEADING_ZERO_BLANK_EN
            snap_blank  <= '0;
`endif
        end else if (tick && wrap) begin
            snap_digits <= digits_in;
            snap_dp     <= dp_in;
`ifdef LEADING_ZERO_BLANK_EN
            snap_blank  <= fresh_blank;
`endif
        end
    end

    // Registered slot outputs, updated only on a tick
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            running   <= 1'b0;
            digit_idx <= '0;
            anode_n   <= '1;
            bcd_out   <= 4'd0;
            dp_out    <= 1'b0;
            bad_digit <= 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
            blank_out <= 1'b0;
`endif
        end else if (tick) begin
            running   <= 1'b1;
            digit_idx <= next_idx;
            anode_n   <= nxt_anode_n;
            bcd_out   <= nxt_bcd;
            dp_out    <= nxt_dp;
            bad_digit <= nxt_bad;
`ifdef LEADING_ZERO_BLANK_EN
            blank_out <= sel_blank;
`endif
        end
    end

endmodule
